snake_btn_dir: RTL and testbench

Input-conditioning stage directly upstream of the snake game state machine. Synchronizes and debounces the five raw pushbuttons, converts direction presses into a committed snake heading that changes only on game ticks, rejects 180° reversals, and toggles a pause flag from the centre button. The game core samples `dir` and `pause` on each `game_tick`.

---
 rtl/snake_pkg.sv | 24 ++
 rtl/snake_debounce.sv | 53 +++++
 rtl/snake_btn_dir.sv | 139 +++++++++++++
 tb/tb_snake_btn_dir.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared heading type, button indices and helpers for the snake input stage
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  localparam dir_t DIR_RESET = DIR_RIGHT;

  localparam int NUM_BTN = 5;
  localparam int BTN_U   = 0;
  localparam int BTN_R   = 1;
  localparam int BTN_D   = 2;
  localparam int BTN_L   = 3;
  localparam int BTN_C   = 4;

  function automatic dir_t dir_opposite(input dir_t d);
    return dir_t'(d ^ 2'b10);
  endfunction

endpackage

// File: rtl/snake_debounce.sv
// rtl/snake_debounce.sv - one-bit 2-flop synchronizer, stability-counter debouncer and rise pulse
module snake_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic board_clk,
  input  logic reset,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Flip on the cycle the counter would reach DEBOUNCE_CYCLES, so a clean edge lands 2 + N cycles later.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = ~level_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      prev_q  <= level_q;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = level_q & ~prev_q;

endmodule

// File: rtl/snake_btn_dir.sv
// rtl/snake_btn_dir.sv - button conditioning, tick-committed heading and pause toggle for the snake core
// SNAKE_DIR_QUEUE_EN: pending turns held in a 2-entry FIFO instead of a single last-wins slot.
module snake_btn_dir
  import snake_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       board_clk,
  input  logic       reset,
  input  logic       btn_u,
  input  logic       btn_r,
  input  logic       btn_d,
  input  logic       btn_l,
  input  logic       btn_c,
  input  logic       game_tick,
  output logic [1:0] dir,
  output logic       pause,
  output logic [4:0] btn_db
);

  logic [NUM_BTN-1:0] raw, level, rise;

  assign raw = {btn_c, btn_l, btn_d, btn_r, btn_u};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
    snake_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .board_clk(board_clk),
      .reset    (reset),
      .btn_i    (raw[i]),
      .level_o  (level[i]),
      .rise_o   (rise[i])
    );
  end

  dir_t press_dir;
  logic press_vld;

  always_comb begin
    press_vld = |rise[BTN_L:BTN_U];
    press_dir = DIR_UP;
    if (rise[BTN_U])      press_dir = DIR_UP;
    else if (rise[BTN_R]) press_dir = DIR_RIGHT;
    else if (rise[BTN_D]) press_dir = DIR_DOWN;
    else if (rise[BTN_L]) press_dir = DIR_LEFT;
  end

  dir_t dir_q, dir_d;
  logic pause_q, pause_d;
  dir_t ref_dir;
  dir_t commit_dir;
  logic commit;
  logic turn_ok;

  assign turn_ok = press_vld & ~pause_q &
                   (press_dir != ref_dir) & (press_dir != dir_opposite(ref_dir));

`ifdef SNAKE_DIR_QUEUE_EN
  dir_t       fifo_q [2];
  dir_t       fifo_d [2];
  logic [1:0] qcnt_q, qcnt_d;
  logic [1:0] qcnt_pop;

  // Pop happens before push, so a tick frees a slot for a press arriving in the same cycle.
  always_comb begin
    ref_dir    = (qcnt_q == 2'd0) ? dir_q : ((qcnt_q == 2'd2) ? fifo_q[1] : fifo_q[0]);
    commit     = game_tick & ~pause_q & (qcnt_q != 2'd0);
    commit_dir = fifo_q[0];
    fifo_d[0]  = commit ? fifo_q[1] : fifo_q[0];
    fifo_d[1]  = fifo_q[1];
    qcnt_pop   = qcnt_q - {1'b0, commit};
    qcnt_d     = qcnt_pop;
    if (turn_ok && qcnt_pop != 2'd2) begin
      fifo_d[qcnt_pop[0]] = press_dir;
      qcnt_d              = qcnt_pop + 2'd1;
    end
  end

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      fifo_q[0] <= DIR_UP;
      fifo_q[1] <= DIR_UP;
      qcnt_q    <= 2'd0;
    end else begin
      fifo_q[0] <= fifo_d[0];
      fifo_q[1] <= fifo_d[1];
      qcnt_q    <= qcnt_d;
    end
  end
`else
  dir_t pend_q, pend_d;
  logic pend_vld_q, pend_vld_d;

  always_comb begin
    ref_dir    = pend_vld_q ? pend_q : dir_q;
    commit     = game_tick & ~pause_q & pend_vld_q;
    commit_dir = pend_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q & ~commit;
    if (turn_ok) begin
      pend_d     = press_dir;
      pend_vld_d = 1'b1;
    end
  end

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      pend_q     <= DIR_UP;
      pend_vld_q <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
    end
  end
`endif

  always_comb begin
    dir_d   = commit ? commit_dir : dir_q;
    pause_d = pause_q ^ rise[BTN_C];
  end

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      dir_q   <= DIR_RESET;
      pause_q <= 1'b0;
    end else begin
      dir_q   <= dir_d;
      pause_q <= pause_d;
    end
  end

  assign dir    = dir_q;
  assign pause  = pause_q;
  assign btn_db = level;

endmodule

// File: tb/tb_snake_btn_dir.sv
// tb/tb_snake_btn_dir.sv - directed and randomized self-checking bench for snake_btn_dir
module tb_snake_btn_dir;

  localparam int DEB = 4;

  logic       board_clk = 1'b0;
  logic       reset     = 1'b1;
  logic       btn_u = 1'b0, btn_r = 1'b0, btn_d = 1'b0, btn_l = 1'b0, btn_c = 1'b0;
  logic       game_tick = 1'b0;
  logic [1:0] dir;
  logic       pause;
  logic [4:0] btn_db;

  int checks   = 0;
  int failures = 0;

  // Event-level reference: heading, pause flag and a queue of pending turns.
  int m_dir;
  bit m_pause;
  int m_q[$];

  snake_btn_dir #(.DEBOUNCE_CYCLES(DEB)) dut (
    .board_clk(board_clk),
    .reset    (reset),
    .btn_u    (btn_u),
    .btn_r    (btn_r),
    .btn_d    (btn_d),
    .btn_l    (btn_l),
    .btn_c    (btn_c),
    .game_tick(game_tick),
    .dir      (dir),
    .pause    (pause),
    .btn_db   (btn_db)
  );

  always #5 board_clk = ~board_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge board_clk);
      #1;
    end
  endtask

  task automatic set_btns(input logic [4:0] m);
    {btn_c, btn_l, btn_d, btn_r, btn_u} = m;
  endtask

  task automatic model_tick();
    if (!m_pause && m_q.size() > 0) m_dir = m_q.pop_front();
  endtask

  task automatic model_press(input logic [4:0] m);
    int d, r;
    if (!m_pause && m[3:0] != 4'b0) begin
      d = m[0] ? 0 : m[1] ? 1 : m[2] ? 2 : 3;
      r = (m_q.size() > 0) ? m_q[$] : m_dir;
      if (d != r && d != (r ^ 2)) begin
`ifdef SNAKE_DIR_QUEUE_EN
        if (m_q.size() < 2) m_q.push_back(d);
`else
        m_q.delete();
        m_q.push_back(d);
`endif
      end
    end
    if (m[4]) m_pause = !m_pause;
  endtask

  task automatic do_reset();
    set_btns(5'b0);
    game_tick = 1'b0;
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(1);
    m_dir   = 1;
    m_pause = 1'b0;
    m_q.delete();
  endtask

  task automatic tick();
    game_tick = 1'b1;
    step(1);
    game_tick = 1'b0;
    step(1);
    model_tick();
  endtask

  // Clean press: debounced level is up after 2 + DEB cycles; with_tick lands the tick on the rise pulse.
  task automatic press(input logic [4:0] m, input bit with_tick, input int extra);
    set_btns(m);
    step(DEB + 2);
    chk("db_level", {3'b0, btn_db}, {3'b0, m});
    if (with_tick) game_tick = 1'b1;
    step(1);
    game_tick = 1'b0;
    step(extra);
    set_btns(5'b0);
    step(DEB + 4);
    if (with_tick) model_tick();
    model_press(m);
  endtask

  task automatic check_model();
    chk("rand_dir", {6'b0, dir}, 8'(m_dir));
    chk("rand_pause", {7'b0, pause}, {7'b0, m_pause});
    chk("rand_btn_db", {3'b0, btn_db}, 8'd0);
  endtask

  initial begin
    logic [4:0] m;
    int         act;

    do_reset();
    chk("reset_dir", {6'b0, dir}, 8'd1);
    chk("reset_pause", {7'b0, pause}, 8'd0);
    chk("reset_btn_db", {3'b0, btn_db}, 8'd0);
    tick();
    chk("idle_tick_dir", {6'b0, dir}, 8'd1);

    set_btns(5'b00001);
    step(3);
    set_btns(5'b0);
    step(8);
    chk("glitch_btn_db", {3'b0, btn_db}, 8'd0);
    tick();
    chk("glitch_dir", {6'b0, dir}, 8'd1);

    set_btns(5'b00001);
    step(5);
    chk("db_cycle5", {3'b0, btn_db}, 8'd0);
    step(1);
    chk("db_cycle6", {3'b0, btn_db}, 8'd1);
    step(4);
    set_btns(5'b0);
    step(8);
    tick();
    chk("hold_up_dir", {6'b0, dir}, 8'd0);

    do_reset();
    press(5'b01000, 1'b0, 0);
    tick();
    chk("reverse_drop", {6'b0, dir}, 8'd1);
    press(5'b00100, 1'b0, 0);
    press(5'b01000, 1'b0, 1);
    tick();
`ifdef SNAKE_DIR_QUEUE_EN
    chk("first_turn", {6'b0, dir}, 8'd2);
`else
    chk("first_turn", {6'b0, dir}, 8'd3);
`endif
    tick();
    chk("second_turn", {6'b0, dir}, 8'd3);

    press(5'b10000, 1'b0, 0);
    chk("pause_on", {7'b0, pause}, 8'd1);
    press(5'b00001, 1'b0, 0);
    tick();
    chk("paused_dir", {6'b0, dir}, 8'd3);
    press(5'b10000, 1'b0, 0);
    chk("pause_off", {7'b0, pause}, 8'd0);
    tick();
    chk("paused_press_dropped", {6'b0, dir}, 8'd3);

    press(5'b00001, 1'b0, 0);
    press(5'b10000, 1'b0, 0);
    tick();
    chk("pause_holds_pending", {6'b0, dir}, 8'd3);
    press(5'b10000, 1'b0, 2);
    chk("unpause_no_commit", {6'b0, dir}, 8'd3);
    tick();
    chk("pending_kept", {6'b0, dir}, 8'd0);

    do_reset();
    press(5'b00101, 1'b0, 0);
    tick();
    chk("priority_u_over_d", {6'b0, dir}, 8'd0);
    press(5'b00010, 1'b1, 0);
    chk("tick_with_empty_pending", {6'b0, dir}, 8'd0);
    tick();
    chk("press_on_tick_pending", {6'b0, dir}, 8'd1);
    press(5'b00001, 1'b0, 0);
    press(5'b01000, 1'b1, 0);
    chk("tick_commits_old", {6'b0, dir}, 8'd0);
    tick();
    chk("tick_new_pending", {6'b0, dir}, 8'd3);

    set_btns(5'b00001);
    step(4);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(5);
    chk("reset_mid_db_early", {3'b0, btn_db}, 8'd0);
    step(1);
    chk("reset_mid_db_restart", {3'b0, btn_db}, 8'd1);
    chk("reset_mid_dir", {6'b0, dir}, 8'd1);
    set_btns(5'b0);
    step(8);

    do_reset();
    for (int i = 0; i < 60; i++) begin
      act = $urandom_range(0, 9);
      if (act <= 4) begin
        m = 5'(1 << $urandom_range(0, 3));
        press(m, ($urandom_range(0, 2) == 0), $urandom_range(0, 3));
      end else if (act == 5) begin
        m = {1'b0, 4'($urandom_range(1, 15))};
        press(m, ($urandom_range(0, 2) == 0), $urandom_range(0, 3));
      end else if (act == 6) begin
        m = {1'b1, 4'($urandom_range(0, 15))};
        press(m, ($urandom_range(0, 2) == 0), $urandom_range(0, 3));
      end else if (act == 7) begin
        set_btns(5'($urandom_range(1, 31)));
        step($urandom_range(1, DEB - 1));
        set_btns(5'b0);
        step(DEB + 4);
      end else begin
        tick();
      end
      check_model();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
